// File: rtl/gru_l1_index_collector.sv
// Layer-1 sample-index collector: captures tagged results on each index
// advance into a small FIFO and flags cadence, sequence and overflow errors.
module gru_l1_index_collector #(
   parameter int DW     = 16,
   parameter int TAG_W  = 8,
   parameter int DEPTH  = 8,
   parameter int PERIOD = 10
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [31:0]      index,
   input  logic [DW-1:0]    l1_data,
   output logic [DW-1:0]    out_data,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             period_err,
   output logic             seq_err,
   output logic             overflow,
   output logic [7:0]       drop_cnt,
   input  logic             err_clr
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int EW = TAG_W + DW;
   localparam logic [8:0] PER = 9'(PERIOD);

   typedef enum logic {IDLE, RUN} state_e;

   state_e        state_q, state_d;
   logic [31:0]   prev_idx_q;
   logic [7:0]    gap_q, gap_d;
   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic [EW-1:0] head_q, head_d;
   logic          per_q, per_d;
   logic          seq_q, seq_d;
   logic          ovf_q, ovf_d;
   logic [7:0]    drop_q, drop_d;

   logic [EW-1:0] mem [DEPTH];

   logic          advance;
   logic          empty;
   logic          full;
   logic          pop;
   logic          push;
   logic          drop;
   logic          per_set;
   logic          seq_set;
   logic [8:0]    gap_inc;
   logic [EW-1:0] wdata;

   assign advance = (prev_idx_q != index) && !index[31];
   assign empty   = (wptr_q == rptr_q);
   assign full    = (wptr_q[AW] != rptr_q[AW]) &&
                    (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign pop     = !empty && out_ready;
   assign push    = advance && (!full || pop);
   assign drop    = advance && full && !pop;
   assign gap_inc = {1'b0, gap_q} + 9'd1;
   assign wdata   = {index[TAG_W-1:0], l1_data};

   always_comb begin
      state_d = state_q;
      gap_d   = gap_q;
      per_set = 1'b0;
      seq_set = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (advance) begin
               state_d = RUN;
               gap_d   = 8'd0;
            end
         end
         RUN: begin
            if (index[31]) begin
               state_d = IDLE;
               gap_d   = 8'd0;
            end else if (advance) begin
               gap_d   = 8'd0;
               per_set = (gap_inc != PER);
               seq_set = (index != prev_idx_q + 32'd1);
            end else if (gap_q != 8'hFF) begin
               gap_d = gap_q + 8'd1;
            end
         end
      endcase
   end

   // A same-cycle error outranks err_clr
   always_comb begin
      per_d  = (per_q && !err_clr) || per_set;
      seq_d  = (seq_q && !err_clr) || seq_set;
      ovf_d  = (ovf_q && !err_clr) || drop;
      drop_d = drop_q;
      if (err_clr) begin
         drop_d = drop ? 8'd1 : 8'd0;
      end else if (drop && drop_q != 8'hFF) begin
         drop_d = drop_q + 8'd1;
      end
   end

   // Head register: new entry bypasses memory when it becomes the head
   always_comb begin
      wptr_d = wptr_q + PW'(push);
      rptr_d = rptr_q + PW'(pop);
      head_d = head_q;
      if (wptr_d != rptr_d) begin
         if (rptr_d == wptr_q) begin
            head_d = wdata;
         end else begin
            head_d = mem[rptr_d[AW-1:0]];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wptr_q[AW-1:0]] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= IDLE;
         prev_idx_q <= 32'hFFFF_FFFF;
         gap_q      <= 8'd0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         head_q     <= '0;
         per_q      <= 1'b0;
         seq_q      <= 1'b0;
         ovf_q      <= 1'b0;
         drop_q     <= 8'd0;
      end else begin
         state_q    <= state_d;
         prev_idx_q <= index;
         gap_q      <= gap_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         head_q     <= head_d;
         per_q      <= per_d;
         seq_q      <= seq_d;
         ovf_q      <= ovf_d;
         drop_q     <= drop_d;
      end
   end

   assign out_valid  = !empty;
   assign out_data   = head_q[DW-1:0];
   assign out_tag    = head_q[EW-1:DW];
   assign period_err = per_q;
   assign seq_err    = seq_q;
   assign overflow   = ovf_q;
   assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_gru_l1_index_collector.sv
// Directed bench for gru_l1_index_collector: cadence, sequence, overflow,
// err_clr and mid-stream reset scenarios with hand-computed expectations.
module tb_gru_l1_index_collector;

   logic        clk;
   logic        rstn;
   logic [31:0] index;
   logic [15:0] l1_data;
   logic [15:0] out_data;
   logic [7:0]  out_tag;
   logic        out_valid;
   logic        out_ready;
   logic        period_err;
   logic        seq_err;
   logic        overflow;
   logic [7:0]  drop_cnt;
   logic        err_clr;

   int tests = 0;
   int fails = 0;

   gru_l1_index_collector #(
      .DW(16), .TAG_W(8), .DEPTH(8), .PERIOD(10)
   ) dut (
      .clk(clk), .rstn(rstn), .index(index), .l1_data(l1_data),
      .out_data(out_data), .out_tag(out_tag), .out_valid(out_valid),
      .out_ready(out_ready), .period_err(period_err), .seq_err(seq_err),
      .overflow(overflow), .drop_cnt(drop_cnt), .err_clr(err_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_idx(input logic [31:0] v);
      index   = v;
      l1_data = 16'h1000 + v[15:0];
   endtask

   initial begin
      rstn      = 1'b0;
      index     = 32'h8000_0000;
      l1_data   = 16'h0;
      out_ready = 1'b1;
      err_clr   = 1'b0;
      tick(2);
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_tag", out_tag, 0);
      chk("rst_per", period_err, 0);
      chk("rst_seq", seq_err, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_drop", drop_cnt, 0);
      rstn = 1'b1;
      tick(3);

      // T1: regular cadence, immediate drain
      for (int i = 0; i < 4; i++) begin
         set_idx(32'(i));
         chk("t1_pre_valid", out_valid, 0);
         tick(1);
         chk("t1_valid", out_valid, 1);
         chk("t1_tag", out_tag, 64'(i));
         chk("t1_data", out_data, 64'(16'h1000 + i));
         tick(1);
         chk("t1_popped", out_valid, 0);
         chk("t1_hold", out_data, 64'(16'h1000 + i));
         tick(i == 3 ? 7 : 8);
      end
      chk("t1_per", period_err, 0);
      chk("t1_seq", seq_err, 0);

      // T3: short gap of 9
      set_idx(32'd4);
      tick(1);
      chk("t3_per", period_err, 1);
      chk("t3_seq", seq_err, 0);
      chk("t3_valid", out_valid, 1);
      chk("t3_tag", out_tag, 4);
      tick(7);
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      chk("t3_clr", period_err, 0);
      tick(1);

      // T4: sequence jump 5 -> 7
      set_idx(32'd5);
      tick(1);
      chk("t4_per5", period_err, 0);
      chk("t4_seq5", seq_err, 0);
      tick(9);
      set_idx(32'd7);
      tick(1);
      chk("t4_seq", seq_err, 1);
      chk("t4_per", period_err, 0);
      tick(5);
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      chk("t4_clr_seq", seq_err, 0);
      chk("t4_clr_per", period_err, 0);
      chk("t4_clr_ovf", overflow, 0);
      chk("t4_clr_drop", drop_cnt, 0);
      set_idx(32'h8000_0000);
      tick(3);

      // T2: no drain, 10 advances into 8 entries
      out_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         set_idx(32'(i));
         tick(10);
         if (i == 7) begin
            chk("t2_ovf_full", overflow, 0);
            chk("t2_drop_full", drop_cnt, 0);
         end
      end
      chk("t2_ovf", overflow, 1);
      chk("t2_drop", drop_cnt, 2);
      chk("t2_per", period_err, 0);
      chk("t2_seq", seq_err, 0);
      chk("t2_head_tag", out_tag, 0);
      chk("t2_head_data", out_data, 16'h1000);

      // T5: pop and advance together while full
      set_idx(32'd10);
      out_ready = 1'b1;
      tick(1);
      out_ready = 1'b0;
      chk("t5_drop", drop_cnt, 2);
      chk("t5_valid", out_valid, 1);
      chk("t5_tag", out_tag, 1);
      tick(9);
      set_idx(32'd11);
      tick(1);
      chk("t5_still_full", drop_cnt, 3);

      out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         chk("drain_tag", out_tag, 64'(k < 7 ? k + 1 : 10));
         chk("drain_data", out_data, 64'(16'h1000 + (k < 7 ? k + 1 : 10)));
         tick(1);
      end
      chk("drain_empty", out_valid, 0);
      set_idx(32'h8000_0000);
      tick(2);

      // T6: reset with 3 entries queued
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         set_idx(32'(i));
         tick(10);
      end
      chk("t6_queued", out_valid, 1);
      #2;
      rstn = 1'b0;
      #1;
      chk("t6_valid", out_valid, 0);
      chk("t6_tag", out_tag, 0);
      chk("t6_data", out_data, 0);
      chk("t6_ovf", overflow, 0);
      chk("t6_drop", drop_cnt, 0);
      set_idx(32'h8000_0000);
      out_ready = 1'b1;
      tick(2);
      rstn = 1'b1;
      tick(2);
      for (int i = 0; i < 3; i++) begin
         set_idx(32'(i));
         tick(1);
         chk("t6_re_valid", out_valid, 1);
         chk("t6_re_tag", out_tag, 64'(i));
         tick(9);
      end
      chk("t6_per", period_err, 0);
      chk("t6_seq", seq_err, 0);
      chk("t6_drop_end", drop_cnt, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
